// File: rtl/cobs_pkg.sv
// Shared definitions for the COBS serial receiver: decoder states, UART
// receiver states, FIFO depth and byte width.
package cobs_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FIFO_DEPTH = 2;

  // COBS decoder: waiting for a code byte, or copying bytes of a block.
  typedef enum logic {
    EXPECT_CODE = 1'b0,
    IN_BLOCK    = 1'b1
  } dec_state_t;

  // UART receiver phases.
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver, LSB first, with a two-flop input synchroniser.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   rxd          : asynchronous serial line, idle high
//   flag         : one-cycle strobe per correctly framed byte
//   data         : last correctly framed byte, held until the next one
module uart_rx_8n1
  import cobs_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 234
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic              flag,
  output logic [BYTE_W-1:0] data
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic              sync1;
  logic              sync2;
  logic              line_q;
  rx_state_t         state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shift;

  // Synchroniser, edge detector and bit-timing FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      line_q  <= 1'b1;
      state   <= RX_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      flag    <= 1'b0;
      data    <= '0;
    end else begin
      sync1  <= rxd;
      sync2  <= sync1;
      line_q <= sync2;
      flag   <= 1'b0;
      case (state)
        RX_IDLE: begin
          // Falling edge on the synchronised line marks a candidate start bit.
          if (line_q && !sync2) begin
            state   <= RX_START;
            clk_cnt <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            // A line back high at mid start bit was a glitch.
            state   <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shift   <= {sync2, shift[BYTE_W-1:1]};
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (sync2) begin
              flag  <= 1'b1;
              data  <= shift;
              state <= RX_IDLE;
            end else begin
              // Framing error: drop the byte and wait for idle before re-arming.
              state <= RX_WAIT_HIGH;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (sync2) begin
            state <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cobs_serial_rx.sv
// UART receiver followed by a COBS frame decoder and a small output FIFO.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   rxd       : asynchronous serial line, idle high
//   busy      : consumer backpressure, no o_flag while high
//   rx_flag   : one-cycle strobe per raw byte received
//   rx_data   : last raw byte received
//   o_flag    : one-cycle strobe per decoded payload byte
//   o_data    : decoded byte, held after the strobe
//   o_eof     : one-cycle strobe when a 0x00 delimiter is received
module cobs_serial_rx
  import cobs_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 27000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  input  logic              busy,
  output logic              rx_flag,
  output logic [BYTE_W-1:0] rx_data,
  output logic              o_flag,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_eof
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W       = $clog2(FIFO_DEPTH + 1);

  uart_rx_8n1 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .flag(rx_flag),
    .data(rx_data)
  );

  dec_state_t        dec_state;
  logic              first_block;
  logic [7:0]        cnt;
  logic [7:0]        lastcode;

  logic [BYTE_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [FCNT_W-1:0] fifo_cnt;

  logic              push_c;
  logic [BYTE_W-1:0] push_byte_c;
  logic              push_ok_c;
  logic              pop_c;

  // Which decoded byte, if any, the current received byte produces.
  always_comb begin
    push_c      = 1'b0;
    push_byte_c = rx_data;
    if (rx_flag && (rx_data != '0)) begin
      if (dec_state == EXPECT_CODE) begin
        // The zero implied by the previous block is emitted when the next code arrives,
        // so no trailing zero appears at the delimiter.
        push_byte_c = '0;
        push_c      = !first_block && (lastcode != 8'hFF);
      end else begin
        push_c = 1'b1;
      end
    end
  end

  // Full FIFO drops the byte; the head leaves only every other cycle.
  assign push_ok_c = push_c && (fifo_cnt != FCNT_W'(FIFO_DEPTH));
  assign pop_c     = (fifo_cnt != '0) && !busy && !o_flag;

  // COBS decoder state.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_state   <= EXPECT_CODE;
      first_block <= 1'b1;
      cnt         <= '0;
      lastcode    <= '0;
      o_eof       <= 1'b0;
    end else begin
      o_eof <= 1'b0;
      if (rx_flag) begin
        if (rx_data == '0) begin
          o_eof       <= 1'b1;
          dec_state   <= EXPECT_CODE;
          first_block <= 1'b1;
          cnt         <= '0;
        end else if (dec_state == EXPECT_CODE) begin
          lastcode    <= rx_data;
          cnt         <= rx_data - 8'd1;
          first_block <= 1'b0;
          dec_state   <= (rx_data != 8'd1) ? IN_BLOCK : EXPECT_CODE;
        end else begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            dec_state <= EXPECT_CODE;
          end
        end
      end
    end
  end

  // Output FIFO and registered o_flag/o_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      o_flag   <= 1'b0;
      o_data   <= '0;
    end else begin
      o_flag <= pop_c;
      if (pop_c) begin
        o_data <= fifo_mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push_ok_c) begin
        fifo_mem[wr_ptr] <= push_byte_c;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      case ({push_ok_c, pop_c})
        2'b10:   fifo_cnt <= fifo_cnt + FCNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - FCNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cobs_serial_rx.sv
// Bench for cobs_serial_rx at 1 MHz / 100 kbaud (10 clocks per bit).
module tb_cobs_serial_rx;

  localparam int unsigned CLK_FREQ = 1000000;
  localparam int unsigned BAUD     = 100000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       rxd  = 1'b1;
  logic       busy = 1'b0;
  logic       rx_flag;
  logic [7:0] rx_data;
  logic       o_flag;
  logic [7:0] o_data;
  logic       o_eof;

  cobs_serial_rx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .busy   (busy),
    .rx_flag(rx_flag),
    .rx_data(rx_data),
    .o_flag (o_flag),
    .o_data (o_data),
    .o_eof  (o_eof)
  );

  always #5 clk = ~clk;

  int         checks    = 0;
  int         failures  = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_out[$];
  int         exp_eof   = 0;
  int         eof_seen  = 0;
  int         oflag_seen = 0;
  int         cyc       = 0;
  int         start_cyc = 0;
  int         rx_cyc    = 0;
  logic       busy_q    = 1'b0;
  logic       of_prev   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    busy_q <= busy;
  end

  // Compare process: every raw and decoded byte against the model queues.
  always @(negedge clk) begin
    if (rst) begin
      of_prev = 1'b0;
    end else begin
      if (rx_flag) begin
        rx_cyc = cyc;
        chk("rx_flag_expected", 32'(exp_rx.size() != 0), 1);
        if (exp_rx.size() != 0) chk("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
      end
      if (o_flag) begin
        oflag_seen++;
        chk("o_flag_while_busy", 32'(busy_q), 0);
        chk("o_flag_gap", 32'(of_prev), 0);
        chk("o_flag_expected", 32'(exp_out.size() != 0), 1);
        if (exp_out.size() != 0) chk("o_data", 32'(o_data), 32'(exp_out.pop_front()));
      end
      if (o_eof) eof_seen++;
      of_prev = o_flag;
    end
  end

  // Reference COBS decode of one frame (stops at the first 0x00).
  task automatic cobs_decode(input logic [7:0] f[$], output logic [7:0] d[$]);
    int i;
    int code;
    d = {};
    i = 0;
    while (i < f.size() && f[i] != 8'h00) begin
      code = int'(f[i]);
      i++;
      for (int k = 1; k < code && i < f.size() && f[i] != 8'h00; k++) begin
        d.push_back(f[i]);
        i++;
      end
      if (code != 255 && i < f.size() && f[i] != 8'h00) d.push_back(8'h00);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rxd = 1'b0;
    start_cyc = cyc;
    if (stop_bit) exp_rx.push_back(b);
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // keep < 0: all decoded bytes expected; otherwise only the first 'keep'.
  task automatic send_frame_q(input logic [7:0] f[$], input int keep);
    logic [7:0] d[$];
    cobs_decode(f, d);
    for (int i = 0; i < d.size(); i++) begin
      if (keep < 0 || i < keep) exp_out.push_back(d[i]);
    end
    for (int i = 0; i < f.size(); i++) begin
      if (f[i] == 8'h00) exp_eof++;
      send_byte(f[i], 1'b1);
    end
  endtask

  // Frame given as packed bytes, first byte in the most significant position.
  task automatic send_frame_v(input logic [63:0] v, input int n, input int keep);
    logic [7:0] f[$];
    f = {};
    for (int i = 0; i < n; i++) f.push_back(v[8*(n-1-i) +: 8]);
    send_frame_q(f, keep);
  endtask

  task automatic settle(input string name);
    repeat (40) @(negedge clk);
    chk({name, "_out_left"}, 32'(exp_out.size()), 0);
    chk({name, "_rx_left"}, 32'(exp_rx.size()), 0);
    chk({name, "_eof_count"}, 32'(eof_seen), 32'(exp_eof));
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] d[$];
    int of0;
    int eof0;

    repeat (4) @(negedge clk);
    chk("rst_rx_flag", 32'(rx_flag), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_o_flag", 32'(o_flag), 0);
    chk("rst_o_data", 32'(o_data), 0);
    chk("rst_o_eof", 32'(o_eof), 0);
    rst = 1'b0;

    // Pin the reference decoder with hand-worked frames.
    f = {8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
    cobs_decode(f, d);
    chk("model_a_size", 32'(d.size()), 4);
    chk("model_a_0", 32'(d[0]), 32'h11);
    chk("model_a_2", 32'(d[2]), 32'h00);
    chk("model_a_3", 32'(d[3]), 32'h33);
    f = {8'h01, 8'h01, 8'h00};
    cobs_decode(f, d);
    chk("model_b_size", 32'(d.size()), 1);
    chk("model_b_0", 32'(d[0]), 32'h00);

    // Raw UART byte and its latency from the start edge.
    send_byte(8'hA5, 1'b1);
    repeat (5) @(negedge clk);
    chk("rx_latency_window", 32'((rx_cyc - start_cyc) >= 90 && (rx_cyc - start_cyc) <= 105), 1);
    chk("rx_data_held", 32'(rx_data), 32'hA5);
    send_byte(8'h00, 1'b1);
    exp_eof++;
    settle("uart_a5");

    // Short glitch must not start a byte; a real byte afterwards is received.
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    settle("glitch");
    send_byte(8'h5A, 1'b1);
    send_byte(8'h00, 1'b1);
    exp_eof++;
    settle("after_glitch");

    // Framing error: byte discarded, no strobe.
    send_byte(8'h55, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    settle("framing");
    chk("framing_rx_data_kept", 32'(rx_data), 32'h00);

    // Basic frame with an implied zero.
    of0 = oflag_seen; eof0 = eof_seen;
    send_frame_v(64'h0311_2202_3300, 6, -1);
    settle("frame_a");
    chk("frame_a_oflags", 32'(oflag_seen - of0), 4);
    chk("frame_a_eofs", 32'(eof_seen - eof0), 1);

    // Maximal block: no zero after code 0xFF.
    f = {};
    f.push_back(8'hFF);
    for (int i = 1; i <= 254; i++) f.push_back(8'(i));
    f.push_back(8'h01);
    f.push_back(8'h00);
    cobs_decode(f, d);
    chk("model_ff_size", 32'(d.size()), 254);
    chk("model_ff_last", 32'(d[253]), 32'hFE);
    of0 = oflag_seen;
    send_frame_q(f, -1);
    settle("frame_ff");
    chk("frame_ff_oflags", 32'(oflag_seen - of0), 254);

    // Single zero payload.
    of0 = oflag_seen;
    send_frame_v(64'h0101_00, 3, -1);
    settle("frame_zero");
    chk("frame_zero_oflags", 32'(oflag_seen - of0), 1);
    chk("frame_zero_data", 32'(o_data), 32'h00);

    // Backpressure: bytes wait in the FIFO until busy drops.
    @(negedge clk);
    busy = 1'b1;
    of0 = oflag_seen;
    send_frame_v(64'h03AA_BB00, 4, -1);
    repeat (20) @(negedge clk);
    chk("busy_no_oflag", 32'(oflag_seen - of0), 0);
    busy = 1'b0;
    settle("busy");
    chk("busy_oflags", 32'(oflag_seen - of0), 2);

    // FIFO full under busy: third byte dropped, decoder still tracks the frame.
    busy = 1'b1;
    send_frame_v(64'h04A1_A2A3_00, 5, 2);
    busy = 1'b0;
    settle("drop");
    send_frame_v(64'h025C_00, 3, -1);
    settle("after_drop");

    // Reset mid-frame.
    send_frame_v(64'h0311, 2, -1);
    settle("pre_rst");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_rx_data", 32'(rx_data), 0);
    chk("midrst_o_data", 32'(o_data), 0);
    chk("midrst_o_flag", 32'(o_flag), 0);
    chk("midrst_flags", 32'({rx_flag, o_eof}), 0);
    rst = 1'b0;
    of0 = oflag_seen;
    send_frame_v(64'h0277_00, 3, -1);
    settle("post_rst");
    chk("post_rst_oflags", 32'(oflag_seen - of0), 1);
    chk("post_rst_data", 32'(o_data), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
